// File: rtl/ltc2308_pkg.sv
// Shared types, widths and config-word helper for the LTC2308 scan controller.
package ltc2308_pkg;

    localparam int RESULT_W = 12;
    localparam int CFG_W    = 6;

    // Config-word fixed bits: single-ended, unipolar, no sleep
    localparam logic SD_SINGLE = 1'b1;
    localparam logic UNI       = 1'b1;
    localparam logic SLP       = 1'b0;

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_CONV,
        S_SHIFT,
        S_GAP,
        S_DONE
    } scan_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_CONV,
        F_SHIFT
    } frame_phase_t;

    // Channel number to the 6-bit word shifted out MSB first:
    // S/D, O/S=ch[0], S1=ch[2], S0=ch[1], UNI, SLP
    function automatic logic [CFG_W-1:0] build_cfg(input logic [2:0] ch);
        return {SD_SINGLE, ch[0], ch[2], ch[1], UNI, SLP};
    endfunction

endpackage

// File: rtl/ltc2308_spi_frame.sv
// One LTC2308 frame: CONVST pulse, then 12 SCK periods shifting config out
// on SDI and the previous conversion in from SDO.
module ltc2308_spi_frame
    import ltc2308_pkg::*;
#(
    parameter int SCLK_DIV    = 2,
    parameter int CONV_CYCLES = 64
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_abort,
    input  logic                i_go,
    input  logic [CFG_W-1:0]    i_cfg,
    input  logic                i_sdo,
    output logic                o_convst,
    output logic                o_sck,
    output logic                o_sdi,
    output logic [RESULT_W-1:0] o_data,
    output logic                o_conv_end,
    output logic                o_frame_done
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int SUB_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCLK_DIV - 1);

    frame_phase_t          r_phase;
    logic [CNT_W-1:0]      r_cnt;
    logic [SUB_W-1:0]      r_sub;
    logic [3:0]            r_bit;
    logic [RESULT_W-1:0]   r_tx;
    logic [RESULT_W-1:0]   r_rx;
    logic                  r_convst;
    logic                  r_sck;
    logic                  r_sdi;
    logic                  w_half_end;

    assign w_half_end   = (r_phase == F_SHIFT) && (r_sub == SUB_LAST);
    assign o_conv_end   = (r_phase == F_CONV) && (r_cnt == CNT_LAST);
    assign o_frame_done = w_half_end && r_sck && (r_bit == 4'd11);

    assign o_convst = r_convst;
    assign o_sck    = r_sck;
    assign o_sdi    = r_sdi;
    assign o_data   = r_rx;

    // Frame sequencer: conversion wait, then SCK halves; SDI changes at the
    // start of each low half, SDO is captured as SCK rises.
    always_ff @(posedge clk) begin
        if (i_rst || i_abort) begin
            r_phase  <= F_IDLE;
            r_cnt    <= '0;
            r_sub    <= '0;
            r_bit    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_convst <= 1'b0;
            r_sck    <= 1'b0;
            r_sdi    <= 1'b0;
        end else begin
            case (r_phase)
                F_IDLE: begin
                    if (i_go) begin
                        r_phase  <= F_CONV;
                        r_convst <= 1'b1;
                        r_cnt    <= '0;
                        r_tx     <= {i_cfg, {(RESULT_W-CFG_W){1'b0}}};
                    end
                end
                F_CONV: begin
                    if (o_conv_end) begin
                        r_phase  <= F_SHIFT;
                        r_convst <= 1'b0;
                        r_sck    <= 1'b0;
                        r_sub    <= '0;
                        r_bit    <= '0;
                        r_sdi    <= r_tx[RESULT_W-1];
                        r_tx     <= {r_tx[RESULT_W-2:0], 1'b0};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                F_SHIFT: begin
                    if (w_half_end) begin
                        r_sub <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                            r_rx  <= {r_rx[RESULT_W-2:0], i_sdo};
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit == 4'd11) begin
                                r_phase <= F_IDLE;
                            end else begin
                                r_bit <= r_bit + 4'd1;
                                r_sdi <= r_tx[RESULT_W-1];
                                r_tx  <= {r_tx[RESULT_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_sub <= r_sub + SUB_W'(1);
                    end
                end
                default: r_phase <= F_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// LTC2308 channel scanner: lock handling, scan FSM over NUM_CH+1 pipelined
// frames, and tagging of each returned conversion with its channel.
module ltc2308_scan_ctrl
    import ltc2308_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int SCLK_DIV    = 2,
    parameter int CONV_CYCLES = 64,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                start,
    input  logic                continuous,
    output logic                adc_convst,
    output logic                adc_sck,
    output logic                adc_sdi,
    input  logic                adc_sdo,
    output logic                result_valid,
    output logic [2:0]          result_ch,
    output logic [RESULT_W-1:0] result_data,
    output logic                busy,
    output logic                done
);

    localparam int F_W   = 4;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [F_W-1:0]   LAST_F   = F_W'(NUM_CH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    scan_state_t         r_state;
    logic                r_lock_meta;
    logic                r_lock_s;
    logic [F_W-1:0]      r_f;
    logic [GAP_W-1:0]    r_gap;
    logic                r_valid;
    logic [2:0]          r_ch;
    logic [RESULT_W-1:0] r_data;
    logic                r_busy;
    logic                r_done;

    logic                w_abort;
    logic                w_gap_end;
    logic                w_go;
    logic [F_W-1:0]      w_next_f;
    logic [2:0]          w_next_ch;
    logic [CFG_W-1:0]    w_cfg;
    logic [RESULT_W-1:0] w_data;
    logic                w_conv_end;
    logic                w_frame_done;

    assign w_abort   = (r_state != S_WAIT_LOCK) && !r_lock_s;
    assign w_gap_end = (r_state == S_GAP) && (r_gap == GAP_LAST);
    assign w_go      = !w_abort &&
                       (((r_state == S_IDLE) && (start || continuous)) ||
                        (w_gap_end && (r_f != LAST_F)));

    // Config for the frame being launched; the closing frame re-sends ch0
    assign w_next_f  = (r_state == S_IDLE) ? '0 : r_f + 4'd1;
    assign w_next_ch = (w_next_f == LAST_F) ? 3'd0 : w_next_f[2:0];
    assign w_cfg     = build_cfg(w_next_ch);

    assign result_valid = r_valid;
    assign result_ch    = r_ch;
    assign result_data  = r_data;
    assign busy         = r_busy;
    assign done         = r_done;

    ltc2308_spi_frame #(
        .SCLK_DIV    (SCLK_DIV),
        .CONV_CYCLES (CONV_CYCLES)
    ) u_frame (
        .clk          (clk),
        .i_rst        (rst),
        .i_abort      (w_abort),
        .i_go         (w_go),
        .i_cfg        (w_cfg),
        .i_sdo        (adc_sdo),
        .o_convst     (adc_convst),
        .o_sck        (adc_sck),
        .o_sdi        (adc_sdi),
        .o_data       (w_data),
        .o_conv_end   (w_conv_end),
        .o_frame_done (w_frame_done)
    );

    // Two-flop synchroniser for the PLL lock
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Scan FSM: frame f's data belongs to channel f-1, strobed on entry to GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT_LOCK;
            r_f     <= '0;
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (w_abort) begin
                r_state <= S_WAIT_LOCK;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT_LOCK: begin
                        if (r_lock_s) r_state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (start || continuous) begin
                            r_state <= S_CONV;
                            r_f     <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_CONV: begin
                        if (w_conv_end) r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (w_frame_done) begin
                            r_state <= S_GAP;
                            r_gap   <= '0;
                            if (r_f != '0) begin
                                r_valid <= 1'b1;
                                r_ch    <= 3'(r_f - 4'd1);
                                r_data  <= w_data;
                            end
                        end
                    end
                    S_GAP: begin
                        if (w_gap_end) begin
                            r_f <= r_f + 4'd1;
                            if (r_f == LAST_F) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= S_CONV;
                            end
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_WAIT_LOCK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Directed bench for ltc2308_scan_ctrl with an LTC2308 SDO/SDI model and
// result/config scoreboards.
module tb_ltc2308_scan_ctrl;

    localparam int NUM_CH      = 8;
    localparam int SCLK_DIV    = 2;
    localparam int CONV_CYCLES = 64;
    localparam int GAP_CYCLES  = 2;
    localparam int FRAME       = CONV_CYCLES + 24*SCLK_DIV + GAP_CYCLES;
    localparam int SCAN        = (NUM_CH + 1) * FRAME;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        adc_sdo = 1'b0;
    logic        adc_convst, adc_sck, adc_sdi;
    logic        result_valid, busy, done;
    logic [2:0]  result_ch;
    logic [11:0] result_data;

    always #5 clk = ~clk;

    ltc2308_scan_ctrl #(
        .NUM_CH(NUM_CH), .SCLK_DIV(SCLK_DIV),
        .CONV_CYCLES(CONV_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .start(start),
        .continuous(continuous), .adc_convst(adc_convst), .adc_sck(adc_sck),
        .adc_sdi(adc_sdi), .adc_sdo(adc_sdo), .result_valid(result_valid),
        .result_ch(result_ch), .result_data(result_data), .busy(busy), .done(done)
    );

    typedef struct { logic [2:0] ch; logic [11:0] data; } exp_t;
    exp_t        exp_q[$];
    logic [11:0] sdi_q[$];
    logic [11:0] m_val [0:7] = '{12'hA5C, 12'h3F1, 12'h000, 12'hFFF,
                                 12'h555, 12'hAAA, 12'h123, 12'h800};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model and frame/result monitors, all sampled on the falling edge
    bit          mon_en = 1'b1;
    bit          frame_open;
    int          sck_cnt, conv_len, n_frames, n_strobes, n_done;
    logic [11:0] sdi_word, m_tx, e_sdi;
    logic [2:0]  m_ch;
    logic        p_convst, p_sck;
    exp_t        e_res;

    always @(negedge clk) begin
        if (rst) begin
            frame_open = 0; sck_cnt = 0; conv_len = 0; sdi_word = '0;
            m_tx = '0; m_ch = '0; p_convst = 0; p_sck = 0; adc_sdo = 1'b0;
        end else begin
            if (!mon_en) frame_open = 0;
            if (adc_convst && !p_convst) begin
                if (frame_open) chk("sck_per_frame", sck_cnt, 12);
                frame_open = mon_en;
                n_frames++;
                sck_cnt = 0; conv_len = 0; sdi_word = '0;
                m_tx = m_val[m_ch];
                adc_sdo = m_tx[11];
            end
            if (adc_convst) conv_len++;
            if (!adc_convst && p_convst && mon_en) chk("convst_len", conv_len, CONV_CYCLES);
            if (adc_sck && !p_sck) begin
                sdi_word = {sdi_word[10:0], adc_sdi};
                sck_cnt++;
                if (sck_cnt == 6) m_ch = {sdi_word[3], sdi_word[2], sdi_word[4]};
            end
            if (!adc_sck && p_sck) begin
                m_tx = {m_tx[10:0], 1'b0};
                adc_sdo = m_tx[11];
                if (sck_cnt == 12 && mon_en) begin
                    chk("sdi_q_nonempty", sdi_q.size() != 0, 1);
                    if (sdi_q.size() != 0) begin
                        e_sdi = sdi_q.pop_front();
                        chk("sdi_word", sdi_word, e_sdi);
                    end
                end
            end
            if (result_valid) begin
                n_strobes++;
                chk("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_res = exp_q.pop_front();
                    chk("result_ch", result_ch, e_res.ch);
                    chk("result_data", result_data, e_res.data);
                end
            end
            if (done) n_done++;
            p_convst = adc_convst;
            p_sck = adc_sck;
        end
    end

    task automatic expect_scan();
        logic [3:0] fb;
        for (int c = 0; c < NUM_CH; c++) exp_q.push_back('{3'(c), m_val[c]});
        for (int f = 0; f <= NUM_CH; f++) begin
            fb = 4'(f);
            sdi_q.push_back({1'b1, fb[0], fb[2], fb[1], 1'b1, 1'b0, 6'b0});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output int busy_low);
        cyc = 0; busy_low = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (done !== 1'b1 && busy !== 1'b1) busy_low++;
        end while (done !== 1'b1 && cyc < budget);
        chk("done_seen", done, 1);
    endtask

    int cyc, bl, ns, nd, nf, base, g;

    initial begin
        // Reset with lock present
        repeat (4) @(negedge clk);
        chk("rst_convst", adc_convst, 0);
        chk("rst_sck", adc_sck, 0);
        chk("rst_sdi", adc_sdi, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_ch", result_ch, 0);
        chk("rst_data", result_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        pulse_start();                       // before lock_s: ignored
        repeat (6) @(negedge clk);
        chk("early_start_busy", busy, 0);
        chk("early_start_frames", n_frames, 0);

        // Full scan: latency, busy, results, SDI words
        expect_scan();
        pulse_start();
        chk("convst_at_start", adc_convst, 1);
        chk("busy_at_start", busy, 1);
        wait_done(3*SCAN, cyc, bl);
        chk("done_latency", cyc, SCAN);
        chk("busy_throughout", bl, 0);
        chk("busy_at_done", busy, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        repeat (4) @(negedge clk);
        chk("scan1_strobes", n_strobes, NUM_CH);
        chk("scan1_res_q", exp_q.size(), 0);
        chk("scan1_sdi_q", sdi_q.size(), 0);

        // Lock loss mid-SHIFT of frame 3
        ns = n_strobes; nd = n_done; base = n_frames;
        expect_scan();
        pulse_start();
        cyc = 0;
        while (n_frames < base + 4 && cyc < 2*SCAN) begin @(negedge clk); cyc++; end
        chk("frame3_reached", n_frames - base, 4);
        repeat (CONV_CYCLES + 20) @(negedge clk);
        mon_en = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        chk("lock_convst", adc_convst, 0);
        chk("lock_sck", adc_sck, 0);
        chk("lock_sdi", adc_sdi, 0);
        chk("lock_busy", busy, 0);
        repeat (300) @(negedge clk);
        chk("lock_strobes", n_strobes - ns, 2);
        chk("lock_no_done", n_done - nd, 0);
        exp_q.delete();
        sdi_q.delete();
        pll_locked = 1'b1;
        repeat (6) @(negedge clk);
        mon_en = 1'b1;

        // Clean scan after relock, with a start pulse while busy
        ns = n_strobes;
        expect_scan();
        pulse_start();
        repeat (400) @(negedge clk);
        pulse_start();
        wait_done(3*SCAN, cyc, bl);
        chk("relock_latency", cyc + 401, SCAN);
        repeat (5) @(negedge clk);
        chk("relock_strobes", n_strobes - ns, NUM_CH);
        chk("relock_res_q", exp_q.size(), 0);
        chk("relock_sdi_q", sdi_q.size(), 0);
        nf = n_frames;
        repeat (200) @(negedge clk);
        chk("no_queued_start", n_frames - nf, 0);
        chk("idle_busy", busy, 0);

        // Continuous mode: back-to-back scans, then stop after the current one
        ns = n_strobes; nd = n_done;
        expect_scan();
        continuous = 1'b1;
        @(negedge clk);
        wait_done(3*SCAN, cyc, bl);
        chk("cont_latency", cyc, SCAN);
        expect_scan();
        g = 0;
        do begin @(negedge clk); g++; end while (adc_convst !== 1'b1 && g < 10);
        chk("cont_gap", g, 2);
        chk("cont_busy", busy, 1);
        continuous = 1'b0;
        wait_done(3*SCAN, cyc, bl);
        chk("cont_latency2", cyc, SCAN);
        chk("cont_busy_thru", bl, 0);
        repeat (5) @(negedge clk);
        chk("cont_strobes", n_strobes - ns, 2*NUM_CH);
        chk("cont_dones", n_done - nd, 2);
        chk("cont_res_q", exp_q.size(), 0);
        chk("cont_sdi_q", sdi_q.size(), 0);
        nf = n_frames;
        repeat (300) @(negedge clk);
        chk("cont_stopped", n_frames - nf, 0);
        chk("cont_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
